// File: rtl/score_cmd_if.sv
// Console-to-arbiter command bus: two request/op/ack channels, counter pulses,
// saturation flag and the BCD score mirror.
interface score_cmd_if;
    logic       req0;
    logic [1:0] op0;
    logic       ack0;
    logic       req1;
    logic [1:0] op1;
    logic       ack1;
    logic       sat;
    logic       inc;
    logic       dec;
    logic       clr;
    logic [3:0] score1;
    logic [3:0] score0;
    logic       busy;

    modport master (
        output req0, op0, req1, op1,
        input  ack0, ack1, sat, inc, dec, clr, score1, score0, busy
    );

    modport slave (
        input  req0, op0, req1, op1,
        output ack0, ack1, sat, inc, dec, clr, score1, score0, busy
    );
endinterface

// File: rtl/score_cmd_arbiter.sv
// Round-robin arbiter feeding inc/dec/clr pulses from two referee consoles to a
// saturating 2-digit BCD score counter, with a local BCD mirror of the score.
module score_cmd_arbiter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    score_cmd_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, GRANT, ISSUE, GAP} state_t;

    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Callers guarantee v != 99 for increment and v != 00 for decrement.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic            last_grant;
    logic            win_id;
    logic [1:0]      win_op;
    logic [7:0]      score;
    logic            ack0, ack1, sat, inc, dec, clr, busy;
    logic            any_req;
    logic            grant_sel;

    assign any_req   = bus.req0 | bus.req1;
    // On a tie the console that did not win last time goes next.
    assign grant_sel = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;

    // Latched command is plain data; it only matters once GRANT is entered.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            win_id <= grant_sel;
            win_op <= grant_sel ? bus.op1 : bus.op0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            score      <= 8'h00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            sat        <= 1'b0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            clr        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            sat  <= 1'b0;
            inc  <= 1'b0;
            dec  <= 1'b0;
            clr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= grant_sel;
                        busy       <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    ack0  <= ~win_id;
                    ack1  <= win_id;
                    state <= ISSUE;
                    case (win_op)
                        OP_INC: begin
                            if (score == 8'h99) sat <= 1'b1;
                            else                inc <= 1'b1;
                        end
                        OP_DEC: begin
                            if (score == 8'h00) sat <= 1'b1;
                            else                dec <= 1'b1;
                        end
                        OP_CLR:  clr <= 1'b1;
                        default: ;
                    endcase
                end
                ISSUE: begin
                    // Mirror follows the pulse just issued.
                    if (inc)      score <= bcd_inc(score);
                    else if (dec) score <= bcd_dec(score);
                    else if (clr) score <= 8'h00;
                    gap_cnt <= '0;
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0   = ack0;
    assign bus.ack1   = ack1;
    assign bus.sat    = sat;
    assign bus.inc    = inc;
    assign bus.dec    = dec;
    assign bus.clr    = clr;
    assign bus.busy   = busy;
    assign bus.score1 = score[7:4];
    assign bus.score0 = score[3:0];

endmodule
